// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // One extra bit so the bit counter never wraps before the terminal compare.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, time-shared by the serial adder as its datapath slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full_adder cell, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fa_s, fa_co;

    full_adder u_full_adder (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Subtract as a + ~b + 1; cin is ignored in that mode.
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub | cin;
`else
                    b_sh_d  = b;
                    carry_d = cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                sum_d  = sum_q >> 1;
                sum_d[WIDTH-1] = fa_s;
                carry_d = fa_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances), scoreboard based.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub1;
`endif

    logic [8:0] sb8[$];
    logic [1:0] sb1[$];
    int n_tests = 0;
    int n_fail  = 0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
`endif
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub1),
`endif
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op on the 8-bit DUT, check latency and result; leaves the DUT in DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        logic [8:0] exp;
        int lat;
        a8 = a;
        b8 = b;
        cin8 = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = s;
`endif
        in_valid8 = 1'b1;
        exp = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
        sb8.push_back(exp);
        n_tests++;
        if (in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL op8_in_ready: got %b want 1", in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        cin8 = ~c;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 40) begin
            n_tests++;
            if (busy8 !== 1'b1) begin
                n_fail++;
                $display("FAIL op8_busy: got %b want 1 at edge %0d", busy8, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL op8_latency: got %0d edges want 8", lat);
        end
        n_tests++;
        if (sb8.size() == 0) begin
            n_fail++;
            $display("FAIL op8_scoreboard: got empty queue want 1 entry");
        end else begin
            exp = sb8.pop_front();
            if ({cout8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL op8_result: got cout=%b sum=%h want cout=%b sum=%h",
                         cout8, sum8, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic drain8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        n_tests++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL drain8: got in_ready=%b busy=%b out_valid=%b want 1 0 0",
                     in_ready8, busy8, out_valid8);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1 ||
            sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: got ov=%b busy=%b ir=%b sum=%h cout=%b want 0 0 1 00 0",
                     out_valid8, busy8, in_ready8, sum8, cout8);
        end
        n_tests++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b1 ||
            sum1 !== 1'b0 || cout1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset1: got ov=%b busy=%b ir=%b sum=%b cout=%b want 0 0 1 0 0",
                     out_valid1, busy1, in_ready1, sum1, cout1);
        end
    endtask

    task automatic test_add();
        op8(8'h35, 8'h4A, 1'b0, 1'b0);
        n_tests++;
        if (sum8 !== 8'h7F || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_35_4a: got sum=%h cout=%b want 7f 0", sum8, cout8);
        end
        drain8();
        op8(8'hA5, 8'h3C, 1'b1, 1'b0);
        drain8();
    endtask

    task automatic test_carry();
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        drain8();
        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        n_tests++;
        if (sum8 !== 8'hFF || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ff_ff_1: got sum=%h cout=%b want ff 1", sum8, cout8);
        end
        drain8();
    endtask

    task automatic test_hold();
        op8(8'h0F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== 8'h10 || cout8 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_done: got ov=%b ir=%b sum=%h cout=%b want 1 0 10 0",
                         out_valid8, in_ready8, sum8, cout8);
            end
        end
        in_valid8 = 1'b0;
        drain8();
    endtask

    task automatic test_reset_mid();
        a8 = 8'hC3;
        b8 = 8'h5A;
        cin8 = 1'b1;
        in_valid8 = 1'b1;
        sb8.push_back({1'b0, 8'hC3} + {1'b0, 8'h5A} + 9'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h00 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got ov=%b busy=%b sum=%h ir=%b want 0 0 00 1",
                     out_valid8, busy8, sum8, in_ready8);
        end
        #2;
        rst = 1'b0;
        void'(sb8.pop_back());
        op8(8'h12, 8'h34, 1'b0, 1'b0);
        n_tests++;
        if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: got sum=%h cout=%b want 46 0", sum8, cout8);
        end
        drain8();
    endtask

    task automatic test_w1();
        int lat;
        int accepts;
        int mst;
        logic [1:0] exp;
        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 1 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_single: got lat=%0d sum=%b cout=%b want 1 1 1", lat, sum1, cout1);
        end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        // Back-to-back with in_valid held high: accepts only when the model is idle.
        in_valid1 = 1'b1;
        mst = 0;
        accepts = 0;
        for (int i = 0; i < 15; i++) begin
            n_tests++;
            if (in_ready1 !== (mst == 0) || out_valid1 !== (mst == 2)) begin
                n_fail++;
                $display("FAIL w1_b2b_state: got ir=%b ov=%b want %b %b at cycle %0d",
                         in_ready1, out_valid1, mst == 0, mst == 2, i);
            end
            if (mst == 2) begin
                n_tests++;
                exp = (sb1.size() != 0) ? sb1.pop_front() : 2'bxx;
                if ({cout1, sum1} !== exp) begin
                    n_fail++;
                    $display("FAIL w1_b2b_result: got cout=%b sum=%b want %b %b",
                             cout1, sum1, exp[1], exp[0]);
                end
            end
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            cin1 = 1'($urandom);
            if (mst == 0) begin
                sb1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
                accepts++;
            end
            mst = (mst == 0) ? 1 : (mst == 1) ? 2 : 0;
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        n_tests++;
        if (accepts != 5 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL w1_b2b_count: got accepts=%0d pending=%0d want 5 0",
                     accepts, sb1.size());
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        op8(8'h10, 8'h20, 1'b0, 1'b1);
        n_tests++;
        if (sum8 !== 8'hF0 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_10_20: got sum=%h cout=%b want f0 0", sum8, cout8);
        end
        drain8();
        op8(8'h20, 8'h10, 1'b0, 1'b1);
        n_tests++;
        if (sum8 !== 8'h10 || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_20_10: got sum=%h cout=%b want 10 1", sum8, cout8);
        end
        drain8();
        op8(8'h20, 8'h10, 1'b1, 1'b0);
        drain8();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        a8 = '0;
        b8 = '0;
        cin8 = 1'b0;
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
        sub1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_add();
        test_carry();
        test_hold();
        test_reset_mid();
        test_w1();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
